// File: rtl/lsu_pkg.sv
// Shared LSU definitions: funct3 encodings, FSM states, byte-lane mask helper.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } lsu_state_e;

    function automatic logic [3:0] byte_mask(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic [3:0] m;
        case (size)
            SZ_B:    m = 4'b0001 << off;
            SZ_H:    m = 4'b0011 << {off[1], 1'b0};
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_load_fmt.sv
// Load data extraction: selects byte/halfword lane and sign- or zero-extends.
module lsu_load_fmt
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] word_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[7:0];
        case (off_i)
            2'd0: byte_sel = word_i[7:0];
            2'd1: byte_sel = word_i[15:8];
            2'd2: byte_sel = word_i[23:16];
            2'd3: byte_sel = word_i[31:24];
            default: byte_sel = word_i[7:0];
        endcase
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        data_o = word_i;
        case (funct3_i)
            F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data_o = {24'd0, byte_sel};
            F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data_o = {16'd0, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory stage: issues loads/stores to a registered data memory, one response per access.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned accesses instead of force-aligning them.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int WORD_AW = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        dmem_en,
    output logic [3:0]  dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_din,
    input  logic [31:0] dmem_dout
);

    lsu_state_e  state_q;
    logic        valid_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        we_q;
    logic        err_q;
    logic [31:0] hold_rdata_q;
    logic        hold_err_q;

    logic [1:0]  size;
    logic        illegal;
    logic        misal;
    logic [1:0]  off_al;
    logic        err_c;
    logic        accept;
    logic        issue;
    logic [31:0] fmt_rdata;
    logic [31:0] wait_rdata;
    logic        unused_addr_hi;

    assign size = req_funct3[1:0];

    assign illegal = (size == 2'b11)
                   || (req_we ? req_funct3[2] : (req_funct3 == 3'b110));

    assign misal = ((size == SZ_H) && req_addr[0])
                || ((size == SZ_W) && (req_addr[1:0] != 2'b00));

    always_comb begin
        case (size)
            SZ_B:    off_al = req_addr[1:0];
            SZ_H:    off_al = {req_addr[1], 1'b0};
            default: off_al = 2'b00;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign err_c = illegal || misal;
`else
    assign err_c = illegal;
    logic unused_misal;
    assign unused_misal = misal;
`endif

    assign req_ready = (state_q == IDLE) || ((state_q == WAIT) && resp_ready);
    assign accept    = req_valid && req_ready;
    // Reset gates the memory port even though req_ready reads high in IDLE.
    assign issue     = accept && !err_c && !rst;

    assign dmem_en   = issue;
    assign dmem_we   = (issue && req_we) ? byte_mask(size, off_al) : 4'b0000;
    assign dmem_addr = 32'(req_addr[WORD_AW+1:2]);

    always_comb begin
        case (size)
            SZ_B:    dmem_din = {4{req_wdata[7:0]}};
            SZ_H:    dmem_din = {2{req_wdata[15:0]}};
            default: dmem_din = req_wdata;
        endcase
    end

    assign unused_addr_hi = ^{req_addr[31:WORD_AW+2]};

    lsu_load_fmt u_fmt (
        .funct3_i (f3_q),
        .off_i    (off_q),
        .word_i   (dmem_dout),
        .data_o   (fmt_rdata)
    );

    assign wait_rdata = (we_q || err_q) ? 32'd0 : fmt_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            valid_q      <= 1'b0;
            f3_q         <= 3'd0;
            off_q        <= 2'd0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            hold_rdata_q <= 32'd0;
            hold_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                f3_q  <= req_funct3;
                off_q <= off_al;
                we_q  <= req_we;
                err_q <= err_c;
            end
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= WAIT;
                        valid_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (resp_ready) begin
                        state_q <= accept ? WAIT : IDLE;
                        valid_q <= accept;
                    end else begin
                        // Memory read data is only valid this cycle; keep a copy.
                        state_q      <= HOLD;
                        hold_rdata_q <= wait_rdata;
                        hold_err_q   <= err_q;
                    end
                end
                HOLD: begin
                    if (resp_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign resp_valid = valid_q;

    always_comb begin
        resp_rdata = 32'd0;
        resp_err   = 1'b0;
        if (state_q == WAIT) begin
            resp_rdata = wait_rdata;
            resp_err   = err_q;
        end else if (state_q == HOLD) begin
            resp_rdata = hold_rdata_q;
            resp_err   = hold_err_q;
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with a registered-read byte-write memory model.
module tb_lsu_mem_stage;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        dmem_en;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_din;
    logic [31:0] dmem_dout;

    int checks;
    int failures;

    logic [31:0] mem [0:1023];

    lsu_mem_stage #(.WORD_AW(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .dmem_en    (dmem_en),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_din   (dmem_din),
        .dmem_dout  (dmem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output is garbage in cycles without an access so stale data is visible.
    always @(posedge clk) begin
        if (dmem_en) begin
            for (int i = 0; i < 4; i++)
                if (dmem_we[i])
                    mem[dmem_addr[9:0]][8*i +: 8] <= dmem_din[8*i +: 8];
            dmem_dout <= mem[dmem_addr[9:0]];
        end else begin
            dmem_dout <= 32'hDEADBEEF;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic rr);
        req_valid  = v;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        resp_ready = rr;
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        dmem_dout = 32'd0;
        rst = 1'b1;
        drv(1, 1, 3'b000, 32'h106, 32'hA5, 1);
        chk("rst_dmem_en", 32'(dmem_en), 0);
        chk("rst_dmem_we", 32'(dmem_we), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_err", 32'(resp_err), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        drv(1, 1, 3'b000, 32'h106, 32'h000000A5, 1);
        chk("sb_en", 32'(dmem_en), 1);
        chk("sb_addr", dmem_addr, 32'h41);
        chk("sb_we", 32'(dmem_we), 32'b0100);
        chk("sb_din", dmem_din, 32'hA5A5A5A5);
        chk("sb_ready", 32'(req_ready), 1);

        nxt();
        drv(1, 1, 3'b010, 32'h104, 32'h8001F0FF, 1);
        chk("sb_resp_valid", 32'(resp_valid), 1);
        chk("sb_resp_rdata", resp_rdata, 0);
        chk("sb_resp_err", 32'(resp_err), 0);
        chk("sw_we", 32'(dmem_we), 32'hF);
        chk("sw_b2b_en", 32'(dmem_en), 1);

        nxt();
        drv(1, 0, 3'b000, 32'h104, 0, 1);
        chk("sw_resp_rdata", resp_rdata, 0);
        chk("lb_we", 32'(dmem_we), 0);
        chk("lb_en", 32'(dmem_en), 1);

        nxt();
        drv(1, 0, 3'b100, 32'h105, 0, 1);
        chk("lb", resp_rdata, 32'hFFFFFFFF);
        nxt();
        drv(1, 0, 3'b001, 32'h106, 0, 1);
        chk("lbu", resp_rdata, 32'h000000F0);
        nxt();
        drv(1, 0, 3'b101, 32'h106, 0, 1);
        chk("lh", resp_rdata, 32'hFFFF8001);
        nxt();
        drv(1, 1, 3'b010, 32'h200, 32'h12345678, 1);
        chk("lhu", resp_rdata, 32'h00008001);
        chk("sw200_ready", 32'(req_ready), 1);
        nxt();
        drv(1, 0, 3'b010, 32'h200, 0, 1);
        chk("lw200_ready", 32'(req_ready), 1);
        chk("lw200_en", 32'(dmem_en), 1);
        nxt();
        drv(0, 0, 3'b010, 0, 0, 1);
        chk("lw200_rdata", resp_rdata, 32'h12345678);
        chk("lw200_valid", 32'(resp_valid), 1);
        nxt();
        chk("idle_valid", 32'(resp_valid), 0);

        drv(1, 0, 3'b010, 32'h200, 0, 0);
        chk("hold_accept", 32'(dmem_en), 1);
        nxt();
        drv(1, 0, 3'b010, 32'h104, 0, 0);
        chk("wait_rdata", resp_rdata, 32'h12345678);
        chk("wait_ready", 32'(req_ready), 0);
        chk("wait_en", 32'(dmem_en), 0);
        for (int k = 0; k < 2; k++) begin
            nxt();
            chk("hold_valid", 32'(resp_valid), 1);
            chk("hold_rdata", resp_rdata, 32'h12345678);
            chk("hold_ready", 32'(req_ready), 0);
            chk("hold_en", 32'(dmem_en), 0);
        end
        nxt();
        drv(1, 0, 3'b010, 32'h104, 0, 1);
        chk("hold_rel_rdata", resp_rdata, 32'h12345678);
        chk("hold_rel_ready", 32'(req_ready), 0);
        chk("hold_rel_en", 32'(dmem_en), 0);
        nxt();
        chk("post_hold_valid", 32'(resp_valid), 0);
        chk("post_hold_ready", 32'(req_ready), 1);
        chk("post_hold_en", 32'(dmem_en), 1);
        nxt();
        drv(0, 0, 0, 0, 0, 1);
        chk("lw104", resp_rdata, 32'h8001F0FF);

        nxt();
        drv(1, 0, 3'b011, 32'h104, 0, 1);
        chk("ill_ld_en", 32'(dmem_en), 0);
        nxt();
        drv(1, 1, 3'b100, 32'h104, 32'hFFFFFFFF, 1);
        chk("ill_ld_err", 32'(resp_err), 1);
        chk("ill_ld_rdata", resp_rdata, 0);
        chk("ill_st_en", 32'(dmem_en), 0);
        chk("ill_st_we", 32'(dmem_we), 0);
        nxt();
        drv(1, 1, 3'b010, 32'h202, 32'hCAFEBABE, 1);
        chk("ill_st_err", 32'(resp_err), 1);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_sw_en", 32'(dmem_en), 0);
        chk("mis_sw_we", 32'(dmem_we), 0);
`else
        chk("mis_sw_addr", dmem_addr, 32'h80);
        chk("mis_sw_we", 32'(dmem_we), 32'hF);
        chk("mis_sw_din", dmem_din, 32'hCAFEBABE);
`endif
        nxt();
        drv(1, 0, 3'b101, 32'h107, 0, 1);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_sw_err", 32'(resp_err), 1);
        chk("mis_lh_en", 32'(dmem_en), 0);
`else
        chk("mis_sw_err", 32'(resp_err), 0);
        chk("mis_lh_en", 32'(dmem_en), 1);
`endif
        nxt();
        drv(0, 0, 0, 0, 0, 1);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_lh_err", 32'(resp_err), 1);
        chk("mis_lh_rdata", resp_rdata, 0);
`else
        chk("mis_lh_err", 32'(resp_err), 0);
        chk("mis_lh_rdata", resp_rdata, 32'h00008001);
`endif

        nxt();
        drv(1, 0, 3'b010, 32'h104, 0, 0);
        nxt();
        drv(0, 0, 0, 0, 0, 0);
        nxt();
        chk("pre_rst_hold", 32'(resp_valid), 1);
        rst = 1'b1;
        #1;
        chk("rst_hold_valid", 32'(resp_valid), 0);
        chk("rst_hold_rdata", resp_rdata, 0);
        chk("rst_hold_err", 32'(resp_err), 0);
        nxt();
        rst = 1'b0;
        drv(1, 0, 3'b010, 32'h200, 0, 1);
        chk("post_rst_en", 32'(dmem_en), 1);
        nxt();
        drv(0, 0, 0, 0, 0, 1);
        chk("post_rst_valid", 32'(resp_valid), 1);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("post_rst_rdata", resp_rdata, 32'h12345678);
`else
        chk("post_rst_rdata", resp_rdata, 32'hCAFEBABE);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
LSU_MEM_STAGE -- requirements
Module: lsu_mem_stage

Interface
REQ-001 SHALL have parameter: WORD_AW, 12, number of word-index bits driven on dmem_addr; upper bits are zero.
REQ-002 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: req_valid in 1; req_we in 1 (1=store); req_funct3 in 3 (RV32I load/store funct3); req_addr in 32 (byte address); req_wdata in 32.
REQ-005 SHALL have port: req_ready  out  1  request accepted on a cycle where req_valid && req_ready.
REQ-006 SHALL have ports: resp_valid out 1; resp_ready in 1; resp_rdata out 32 (formatted load data, 0 for stores); resp_err out 1 (misaligned or illegal access).
REQ-007 SHALL have data-memory ports: dmem_en out 1; dmem_we out 4 (byte write enables); dmem_addr out 32 (word index); dmem_din out 32; dmem_dout in 32 (registered memory read, valid one cycle after dmem_en).

Function
REQ-008 SHALL drive dmem_* combinationally from the request: dmem_en = accept; dmem_addr = zero-extended req_addr[WORD_AW+1:2].
REQ-009 SHALL for stores set dmem_din: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata; dmem_we: SB 4'b0001<<addr[1:0], SH 4'b0011<<{addr[1],1'b0}, SW 4'b1111; loads dmem_we=0.
REQ-010 SHALL use FSM states IDLE, WAIT, HOLD: IDLE->WAIT on accept; WAIT->WAIT on accept with resp_ready; WAIT->IDLE on resp_ready without accept; WAIT->HOLD on !resp_ready; HOLD->IDLE on resp_ready.
REQ-011 SHALL assert resp_valid in WAIT and HOLD only; latency request-accept to resp_valid exactly 1 cycle.
REQ-012 SHALL in WAIT format resp_rdata from dmem_dout using registered funct3 and addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, byte at offset addr[1:0], halfword at addr[1]; LW whole word.
REQ-013 SHALL on WAIT->HOLD capture resp_rdata/resp_err into hold registers and present them unchanged until resp_ready.
REQ-014 SHALL drive req_ready = (state==IDLE) || (state==WAIT && resp_ready); 0 in HOLD; sustained throughput one access per cycle.
REQ-015 SHALL treat funct3 011/110/111 (and 011/1xx on stores) as illegal: dmem_en=0, resp_err=1 in the response cycle.
REQ-016 SHALL, when request accepted simultaneously with response consumption, issue the new access to dmem in that same cycle.

Reset
REQ-017 SHALL on rst force state IDLE, resp_valid 0, resp_rdata 0, resp_err 0, hold registers 0, immediately (asynchronous).
REQ-018 SHALL discard any pending response on reset mid-operation; stores already written to memory are not rolled back.
REQ-019 SHALL drive dmem_en=0, dmem_we=0 while rst is high.

Configuration
REQ-020 SHALL with LSU_MISALIGN_TRAP_EN defined: misaligned access (halfword addr[0]=1, word addr[1:0]!=0) issues no dmem access (dmem_en=0, dmem_we=0) and responds with resp_err=1, resp_rdata=0.
REQ-021 SHALL without LSU_MISALIGN_TRAP_EN: misaligned addresses are force-aligned (addr[0] cleared for halfword, addr[1:0] for word), access proceeds, resp_err reflects only illegal funct3.

Structure
REQ-022 SHALL place funct3 constants, FSM state enum and byte-mask helper in shared package lsu_pkg.
REQ-023 SHALL implement load extraction/sign-extension in combinational sub-module lsu_load_fmt.

Verification
REQ-024 SB addr 0x106 wdata 0xA5 -> dmem_addr 0x41, dmem_we 4'b0100, dmem_din 0xA5A5A5A5, resp_valid next cycle with rdata 0.
REQ-025 Word 0x41 = 0x8001F0FF: LB 0x104 -> 0xFFFFFFFF; LBU 0x105 -> 0x000000F0; LH 0x106 -> 0xFFFF8001; LHU 0x106 -> 0x00008001, each one cycle after accept.
REQ-026 SW 0x200 data 0x12345678 at cycle 0, LW 0x200 at cycle 1 (resp_ready=1) -> resp_rdata 0x12345678 at cycle 2, req_ready high throughout.
REQ-027 LW accepted, resp_ready low 3 cycles -> resp_valid held, resp_rdata stable, req_ready 0, dmem_en 0; resp_ready high -> IDLE next cycle.
REQ-028 SW 0x202: with macro -> dmem_we 0, resp_err 1; without -> dmem_addr 0x80, dmem_we 4'b1111, resp_err 0.
REQ-029 rst asserted while in HOLD -> resp_valid 0 in same cycle; first request after release responds normally.
